// File: rtl/tetris_pkg.sv
// Shared types, board geometry, spawn point, randomizer constants and piece shape tables
// for the Tetris active-piece engine.
package tetris_pkg;

    typedef enum logic [3:0] {
        PC_O = 4'd0,
        PC_I = 4'd1,
        PC_T = 4'd2,
        PC_L = 4'd3,
        PC_J = 4'd4,
        PC_S = 4'd5,
        PC_Z = 4'd6
    } piece_e;

    localparam int BOARD_W = 8;
    localparam int BOARD_H = 8;

    localparam logic [2:0] SPAWN_X   = 3'd3;
    localparam logic [2:0] SPAWN_Y   = 3'd0;
    localparam logic [1:0] SPAWN_ROT = 2'd0;

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;
    localparam logic [7:0] LFSR_TAPS         = 8'b1011_1000;

    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } cell_off_t;

    typedef cell_off_t [3:0] shape_t;

    function automatic piece_e to_piece(input logic [3:0] code);
        piece_e p;
        if (code > 4'd6) p = PC_O;
        else             p = piece_e'(code);
        return p;
    endfunction

    function automatic logic [2:0] box_size(input piece_e p);
        logic [2:0] b;
        case (p)
            PC_O:    b = 3'd2;
            PC_I:    b = 3'd4;
            default: b = 3'd3;
        endcase
        return b;
    endfunction

    function automatic shape_t rot0_shape(input piece_e p);
        shape_t s;
        case (p)
            PC_I: begin
                s[0] = '{dx: 2'd0, dy: 2'd1}; s[1] = '{dx: 2'd1, dy: 2'd1};
                s[2] = '{dx: 2'd2, dy: 2'd1}; s[3] = '{dx: 2'd3, dy: 2'd1};
            end
            PC_T: begin
                s[0] = '{dx: 2'd0, dy: 2'd0}; s[1] = '{dx: 2'd1, dy: 2'd0};
                s[2] = '{dx: 2'd2, dy: 2'd0}; s[3] = '{dx: 2'd1, dy: 2'd1};
            end
            PC_L: begin
                s[0] = '{dx: 2'd0, dy: 2'd0}; s[1] = '{dx: 2'd0, dy: 2'd1};
                s[2] = '{dx: 2'd0, dy: 2'd2}; s[3] = '{dx: 2'd1, dy: 2'd2};
            end
            PC_J: begin
                s[0] = '{dx: 2'd1, dy: 2'd0}; s[1] = '{dx: 2'd1, dy: 2'd1};
                s[2] = '{dx: 2'd1, dy: 2'd2}; s[3] = '{dx: 2'd0, dy: 2'd2};
            end
            PC_S: begin
                s[0] = '{dx: 2'd1, dy: 2'd0}; s[1] = '{dx: 2'd2, dy: 2'd0};
                s[2] = '{dx: 2'd0, dy: 2'd1}; s[3] = '{dx: 2'd1, dy: 2'd1};
            end
            PC_Z: begin
                s[0] = '{dx: 2'd0, dy: 2'd0}; s[1] = '{dx: 2'd1, dy: 2'd0};
                s[2] = '{dx: 2'd1, dy: 2'd1}; s[3] = '{dx: 2'd2, dy: 2'd1};
            end
            default: begin
                s[0] = '{dx: 2'd0, dy: 2'd0}; s[1] = '{dx: 2'd1, dy: 2'd0};
                s[2] = '{dx: 2'd0, dy: 2'd1}; s[3] = '{dx: 2'd1, dy: 2'd1};
            end
        endcase
        return s;
    endfunction

    // Clockwise quarter turn inside the BxB box: (dx,dy) -> (B-1-dy, dx), repeated rot times.
    function automatic cell_off_t cell_offset(input logic [3:0] code,
                                              input logic [1:0] idx,
                                              input logic [1:0] rot);
        piece_e     p;
        shape_t     s;
        logic [2:0] b;
        logic [2:0] dx;
        logic [2:0] dy;
        logic [2:0] t;
        cell_off_t  res;
        p  = to_piece(code);
        s  = rot0_shape(p);
        b  = box_size(p);
        dx = {1'b0, s[idx].dx};
        dy = {1'b0, s[idx].dy};
        for (int k = 0; k < 3; k++) begin
            if (k < int'(rot)) begin
                t  = b - 3'd1 - dy;
                dy = dx;
                dx = t;
            end
        end
        res.dx = dx[1:0];
        res.dy = dy[1:0];
        return res;
    endfunction

endpackage

// File: rtl/piece_footprint.sv
// Combinational footprint of one piece placement: four cell indices plus a flag that all
// cells are on the board and clear of settled blocks. Anchor is 4 bits so x-1 at 0 reads as off-board.
module piece_footprint
    import tetris_pkg::*;
(
    input  logic [3:0]                        i_piece,
    input  logic [3:0]                        i_x,
    input  logic [3:0]                        i_y,
    input  logic [1:0]                        i_rot,
    input  logic [BOARD_H-1:0][BOARD_W-1:0]   i_fallen,
    output logic [3:0][5:0]                   o_blk,
    output logic                              o_legal
);

    cell_off_t  w_off;
    logic [4:0] w_col;
    logic [4:0] w_row;

    always_comb begin
        o_legal = 1'b1;
        o_blk   = '0;
        w_off   = '0;
        w_col   = '0;
        w_row   = '0;
        for (int i = 0; i < 4; i++) begin
            w_off    = cell_offset(i_piece, 2'(i), i_rot);
            w_col    = {1'b0, i_x} + {3'b000, w_off.dx};
            w_row    = {1'b0, i_y} + {3'b000, w_off.dy};
            o_blk[i] = {w_row[2:0], w_col[2:0]};
            if (w_col > 5'd7 || w_row > 5'd7) begin
                o_legal = 1'b0;
            end else if (i_fallen[w_row[2:0]][w_col[2:0]]) begin
                o_legal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tetris_piece_engine.sv
// Active-piece motion engine: picks one request per clock by priority, registers the move
// if its footprint is legal, reports the footprint of the registered position, and runs the randomizer.
module tetris_piece_engine
    import tetris_pkg::*;
#(
    parameter int         BOARD_W   = tetris_pkg::BOARD_W,
    parameter int         BOARD_H   = tetris_pkg::BOARD_H,
    parameter logic [7:0] LFSR_SEED = tetris_pkg::LFSR_SEED_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clk_en,
    input  logic                              btn_right_en,
    input  logic                              btn_left_en,
    input  logic                              btn_rotate_en,
    input  logic                              btn_down_en,
    input  logic [BOARD_H-1:0][BOARD_W-1:0]   fallen,
    input  logic [3:0]                        piece,
    input  logic [2:0]                        cur_pos_x,
    input  logic [2:0]                        cur_pos_y,
    input  logic [1:0]                        cur_rot,
    output logic [2:0]                        new_pos_x,
    output logic [2:0]                        new_pos_y,
    output logic [1:0]                        new_rot,
    output logic [5:0]                        blk_1,
    output logic [5:0]                        blk_2,
    output logic [5:0]                        blk_3,
    output logic [5:0]                        blk_4,
    output logic                              is_possible,
    output logic [3:0]                        random_num
);

    function automatic logic [3:0] mod7(input logic [7:0] v);
        logic [7:0] r;
        r = v % 8'd7;
        return r[3:0];
    endfunction

    logic [2:0]     r_new_pos_x;
    logic [2:0]     r_new_pos_y;
    logic [1:0]     r_new_rot;
    logic [7:0]     r_lfsr;
    logic [3:0]     r_random;

    logic           w_req_down;
    logic           w_req_any;
    logic [3:0]     w_cand_x;
    logic [3:0]     w_cand_y;
    logic [1:0]     w_cand_rot;
    logic           w_cand_legal;
    logic [3:0][5:0] w_cand_blk;
    logic [3:0][5:0] w_new_blk;
    logic           w_new_legal;
    logic [7:0]     w_lfsr_next;

    assign w_req_down = btn_down_en | clk_en;
    assign w_req_any  = btn_rotate_en | btn_left_en | btn_right_en | w_req_down;

    // Only the highest-priority request forms a candidate; lower ones never stand in for it.
    always_comb begin
        w_cand_x   = {1'b0, cur_pos_x};
        w_cand_y   = {1'b0, cur_pos_y};
        w_cand_rot = cur_rot;
        if (btn_rotate_en) begin
            w_cand_rot = cur_rot + 2'd1;
        end else if (btn_left_en) begin
            w_cand_x = {1'b0, cur_pos_x} - 4'd1;
        end else if (btn_right_en) begin
            w_cand_x = {1'b0, cur_pos_x} + 4'd1;
        end else if (w_req_down) begin
            w_cand_y = {1'b0, cur_pos_y} + 4'd1;
        end
    end

    piece_footprint u_cand_fp (
        .i_piece  (piece),
        .i_x      (w_cand_x),
        .i_y      (w_cand_y),
        .i_rot    (w_cand_rot),
        .i_fallen (fallen),
        .o_blk    (w_cand_blk),
        .o_legal  (w_cand_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_new_pos_x <= SPAWN_X;
            r_new_pos_y <= SPAWN_Y;
            r_new_rot   <= SPAWN_ROT;
        end else if (w_req_any && w_cand_legal) begin
            r_new_pos_x <= w_cand_x[2:0];
            r_new_pos_y <= w_cand_y[2:0];
            r_new_rot   <= w_cand_rot;
        end else begin
            r_new_pos_x <= cur_pos_x;
            r_new_pos_y <= cur_pos_y;
            r_new_rot   <= cur_rot;
        end
    end

    piece_footprint u_new_fp (
        .i_piece  (piece),
        .i_x      ({1'b0, r_new_pos_x}),
        .i_y      ({1'b0, r_new_pos_y}),
        .i_rot    (r_new_rot),
        .i_fallen (fallen),
        .o_blk    (w_new_blk),
        .o_legal  (w_new_legal)
    );

    // Fibonacci LFSR; random_num follows the register contents so it always equals lfsr mod 7.
    assign w_lfsr_next = {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr   <= LFSR_SEED;
            r_random <= mod7(LFSR_SEED);
        end else begin
            r_lfsr   <= w_lfsr_next;
            r_random <= mod7(w_lfsr_next);
        end
    end

    assign new_pos_x   = r_new_pos_x;
    assign new_pos_y   = r_new_pos_y;
    assign new_rot     = r_new_rot;
    assign blk_1       = w_new_blk[0];
    assign blk_2       = w_new_blk[1];
    assign blk_3       = w_new_blk[2];
    assign blk_4       = w_new_blk[3];
    assign is_possible = w_new_legal;
    assign random_num  = r_random;

endmodule

// File: tb/tb_tetris_piece_engine.sv
// Directed bench for tetris_piece_engine: movement, legality, priority, reset and randomizer.
module tb_tetris_piece_engine;

    logic            clk = 1'b0;
    logic            rst;
    logic            clk_en;
    logic            btn_right_en;
    logic            btn_left_en;
    logic            btn_rotate_en;
    logic            btn_down_en;
    logic [7:0][7:0] fallen;
    logic [3:0]      piece;
    logic [2:0]      cur_pos_x;
    logic [2:0]      cur_pos_y;
    logic [1:0]      cur_rot;
    logic [2:0]      new_pos_x;
    logic [2:0]      new_pos_y;
    logic [1:0]      new_rot;
    logic [5:0]      blk_1;
    logic [5:0]      blk_2;
    logic [5:0]      blk_3;
    logic [5:0]      blk_4;
    logic            is_possible;
    logic [3:0]      random_num;

    int n_checks = 0;
    int n_fail   = 0;

    tetris_piece_engine dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .btn_right_en  (btn_right_en),
        .btn_left_en   (btn_left_en),
        .btn_rotate_en (btn_rotate_en),
        .btn_down_en   (btn_down_en),
        .fallen        (fallen),
        .piece         (piece),
        .cur_pos_x     (cur_pos_x),
        .cur_pos_y     (cur_pos_y),
        .cur_rot       (cur_rot),
        .new_pos_x     (new_pos_x),
        .new_pos_y     (new_pos_y),
        .new_rot       (new_rot),
        .blk_1         (blk_1),
        .blk_2         (blk_2),
        .blk_3         (blk_3),
        .blk_4         (blk_4),
        .is_possible   (is_possible),
        .random_num    (random_num)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_reqs();
        clk_en        = 1'b0;
        btn_right_en  = 1'b0;
        btn_left_en   = 1'b0;
        btn_rotate_en = 1'b0;
        btn_down_en   = 1'b0;
    endtask

    task automatic set_cur(input logic [2:0] x, input logic [2:0] y, input logic [1:0] r);
        cur_pos_x = x;
        cur_pos_y = y;
        cur_rot   = r;
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] m);
        return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    endfunction

    task automatic test_reset();
        no_reqs();
        fallen = '0;
        piece  = 4'd2;
        set_cur(3'd3, 3'd0, 2'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({new_pos_x, new_pos_y, new_rot} !== {3'd3, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_pos: got x=%0d y=%0d r=%0d want 3 0 0", new_pos_x, new_pos_y, new_rot);
        end
        n_checks++;
        if ({blk_1, blk_2, blk_3, blk_4} !== {6'd3, 6'd4, 6'd5, 6'd12}) begin
            n_fail++;
            $display("FAIL reset_blk: got %0d %0d %0d %0d want 3 4 5 12", blk_1, blk_2, blk_3, blk_4);
        end
        n_checks++;
        if (is_possible !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_possible: got %b want 1", is_possible);
        end
        n_checks++;
        if (random_num !== 4'd4) begin
            n_fail++;
            $display("FAIL reset_random: got %0d want 4", random_num);
        end
    endtask

    task automatic test_collision_live();
        fallen[1][4] = 1'b1;
        #1;
        n_checks++;
        if (is_possible !== 1'b0) begin
            n_fail++;
            $display("FAIL live_collision: got %b want 0", is_possible);
        end
        fallen = '0;
        #1;
    endtask

    task automatic test_left_right();
        no_reqs();
        piece = 4'd0;
        set_cur(3'd0, 3'd2, 2'd0);
        btn_left_en = 1'b1;
        tick();
        n_checks++;
        if (new_pos_x !== 3'd0) begin
            n_fail++;
            $display("FAIL left_wall: got x=%0d want 0", new_pos_x);
        end
        no_reqs();
        set_cur(3'd6, 3'd2, 2'd0);
        btn_right_en = 1'b1;
        tick();
        n_checks++;
        if (new_pos_x !== 3'd6) begin
            n_fail++;
            $display("FAIL right_wall: got x=%0d want 6", new_pos_x);
        end
        set_cur(3'd5, 3'd2, 2'd0);
        tick();
        n_checks++;
        if ({new_pos_x, new_pos_y} !== {3'd6, 3'd2}) begin
            n_fail++;
            $display("FAIL right_move: got x=%0d y=%0d want 6 2", new_pos_x, new_pos_y);
        end
        no_reqs();
        set_cur(3'd4, 3'd2, 2'd0);
        btn_left_en = 1'b1;
        tick();
        n_checks++;
        if (new_pos_x !== 3'd3) begin
            n_fail++;
            $display("FAIL left_move: got x=%0d want 3", new_pos_x);
        end
        no_reqs();
    endtask

    task automatic test_rotate();
        no_reqs();
        piece = 4'd1;
        set_cur(3'd2, 3'd2, 2'd3);
        btn_rotate_en = 1'b1;
        tick();
        n_checks++;
        if ({new_pos_x, new_pos_y, new_rot} !== {3'd2, 3'd2, 2'd0}) begin
            n_fail++;
            $display("FAIL rot_wrap: got x=%0d y=%0d r=%0d want 2 2 0", new_pos_x, new_pos_y, new_rot);
        end
        no_reqs();
        set_cur(3'd2, 3'd0, 2'd1);
        tick();
        n_checks++;
        if ({blk_1, blk_2, blk_3, blk_4} !== {6'd4, 6'd12, 6'd20, 6'd28}) begin
            n_fail++;
            $display("FAIL i_rot1_blk: got %0d %0d %0d %0d want 4 12 20 28", blk_1, blk_2, blk_3, blk_4);
        end
        n_checks++;
        if (is_possible !== 1'b1) begin
            n_fail++;
            $display("FAIL i_rot1_possible: got %b want 1", is_possible);
        end
    endtask

    task automatic test_down();
        no_reqs();
        piece = 4'd0;
        set_cur(3'd3, 3'd5, 2'd0);
        clk_en = 1'b1;
        tick();
        n_checks++;
        if (new_pos_y !== 3'd6) begin
            n_fail++;
            $display("FAIL gravity_step: got y=%0d want 6", new_pos_y);
        end
        set_cur(3'd3, 3'd6, 2'd0);
        tick();
        n_checks++;
        if (new_pos_y !== 3'd6) begin
            n_fail++;
            $display("FAIL floor_block: got y=%0d want 6", new_pos_y);
        end
        no_reqs();
        fallen[4][3] = 1'b1;
        set_cur(3'd3, 3'd2, 2'd0);
        btn_down_en = 1'b1;
        tick();
        n_checks++;
        if (new_pos_y !== 3'd2) begin
            n_fail++;
            $display("FAIL stack_block: got y=%0d want 2", new_pos_y);
        end
        fallen = '0;
        clk_en = 1'b1;
        tick();
        n_checks++;
        if (new_pos_y !== 3'd3) begin
            n_fail++;
            $display("FAIL both_down_single: got y=%0d want 3", new_pos_y);
        end
        no_reqs();
    endtask

    task automatic test_priority();
        no_reqs();
        fallen = '0;
        piece  = 4'd2;
        set_cur(3'd3, 3'd2, 2'd0);
        btn_rotate_en = 1'b1;
        btn_left_en   = 1'b1;
        clk_en        = 1'b1;
        tick();
        n_checks++;
        if ({new_pos_x, new_pos_y, new_rot} !== {3'd3, 3'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL prio_rotate: got x=%0d y=%0d r=%0d want 3 2 1", new_pos_x, new_pos_y, new_rot);
        end
        fallen[3][5] = 1'b1;
        tick();
        n_checks++;
        if ({new_pos_x, new_pos_y, new_rot} !== {3'd3, 3'd2, 2'd0}) begin
            n_fail++;
            $display("FAIL prio_no_fallback: got x=%0d y=%0d r=%0d want 3 2 0", new_pos_x, new_pos_y, new_rot);
        end
        no_reqs();
        btn_right_en = 1'b1;
        btn_down_en  = 1'b1;
        fallen = '0;
        tick();
        n_checks++;
        if ({new_pos_x, new_pos_y} !== {3'd4, 3'd2}) begin
            n_fail++;
            $display("FAIL prio_right_over_down: got x=%0d y=%0d want 4 2", new_pos_x, new_pos_y);
        end
        no_reqs();
    endtask

    task automatic test_back_to_back();
        no_reqs();
        fallen = '0;
        piece  = 4'd0;
        set_cur(3'd1, 3'd1, 2'd0);
        btn_down_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            set_cur(new_pos_x, new_pos_y, new_rot);
        end
        n_checks++;
        if ({new_pos_x, new_pos_y} !== {3'd1, 3'd4}) begin
            n_fail++;
            $display("FAIL b2b_down: got x=%0d y=%0d want 1 4", new_pos_x, new_pos_y);
        end
        n_checks++;
        if ({blk_1, blk_2, blk_3, blk_4} !== {6'd33, 6'd34, 6'd41, 6'd42}) begin
            n_fail++;
            $display("FAIL b2b_blk: got %0d %0d %0d %0d want 33 34 41 42", blk_1, blk_2, blk_3, blk_4);
        end
        no_reqs();
    endtask

    task automatic test_reset_wins();
        no_reqs();
        piece = 4'd0;
        set_cur(3'd5, 3'd5, 2'd2);
        clk_en       = 1'b1;
        btn_left_en  = 1'b1;
        rst          = 1'b1;
        tick();
        rst = 1'b0;
        no_reqs();
        n_checks++;
        if ({new_pos_x, new_pos_y, new_rot} !== {3'd3, 3'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_wins: got x=%0d y=%0d r=%0d want 3 0 0", new_pos_x, new_pos_y, new_rot);
        end
    endtask

    task automatic test_random();
        logic [7:0] m;
        logic [3:0] hist [255];
        int         model_err;
        int         range_err;
        int         rep_err;
        model_err = 0;
        range_err = 0;
        rep_err   = 0;
        no_reqs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m = 8'hA5;
        n_checks++;
        if (random_num !== 4'd4) begin
            n_fail++;
            $display("FAIL rand_after_reset: got %0d want 4", random_num);
        end
        for (int i = 0; i < 255; i++) begin
            tick();
            m = lfsr_step(m);
            hist[i] = random_num;
            if (random_num !== 4'(m % 8'd7)) model_err++;
            if (random_num > 4'd6) range_err++;
        end
        for (int i = 0; i < 255; i++) begin
            tick();
            if (random_num !== hist[i]) rep_err++;
        end
        n_checks++;
        if (model_err !== 0) begin
            n_fail++;
            $display("FAIL rand_sequence: got %0d wrong values want 0", model_err);
        end
        n_checks++;
        if (range_err !== 0) begin
            n_fail++;
            $display("FAIL rand_range: got %0d values above 6 want 0", range_err);
        end
        n_checks++;
        if (rep_err !== 0) begin
            n_fail++;
            $display("FAIL rand_period: got %0d non-repeating values want 0", rep_err);
        end
    endtask

    initial begin
        rst = 1'b0;
        no_reqs();
        fallen = '0;
        piece  = 4'd2;
        set_cur(3'd3, 3'd0, 2'd0);
        #2;
        test_reset();
        test_collision_live();
        test_left_right();
        test_rotate();
        test_down();
        test_priority();
        test_back_to_back();
        test_reset_wins();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tetris_piece_engine.md
Name: tetris_piece_engine

Overview:
- Motion and footprint engine for the active piece on an 8x8 Tetris board. Three functions, each registered where stated:
  - Next position/rotation from button and gravity requests, with legality checks against the settled-block matrix.
  - The four occupied cell indices of the piece at that position.
  - A pseudo-random next-piece code.
- Sits between the debounced button enables and the display/row-check logic. The top level feeds new_* back into cur_* every clock.

Parameters:
- BOARD_W, 8, board columns (x 0..7, bit index within a row).
- BOARD_H, 8, board rows (y 0..7, row 0 = top).
- LFSR_SEED, 8'hA5, randomizer reset value (must be nonzero).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  gravity tick: request one row down.
- btn_right_en  in  1  request x+1.
- btn_left_en  in  1  request x-1.
- btn_rotate_en  in  1  request rot+1.
- btn_down_en  in  1  request one row down.
- fallen  in  8x[7:0]  settled blocks; fallen[y][x]=1 means occupied.
- piece  in  4  active piece code.
- cur_pos_x  in  3  current anchor column.
- cur_pos_y  in  3  current anchor row.
- cur_rot  in  2  current rotation.
- new_pos_x  out  3  registered next anchor column.
- new_pos_y  out  3  registered next anchor row.
- new_rot  out  2  registered next rotation.
- blk_1, blk_2, blk_3, blk_4  out  6 each  cell index {row[2:0],col[2:0]} = y*8+x.
- is_possible  out  1  footprint at new_* is fully in-bounds and collision-free.
- random_num  out  4  next-piece code, always 0..6.

Behaviour:
- Piece codes: 0=O, 1=I, 2=T, 3=L, 4=J, 5=S, 6=Z. Codes 7..15 are treated as O.
- Rot0 offsets (dx,dy) and box size B:
  - O: (0,0)(1,0)(0,1)(1,1), B=2.
  - I: (0,1)(1,1)(2,1)(3,1), B=4.
  - T: (0,0)(1,0)(2,0)(1,1), B=3.
  - L: (0,0)(0,1)(0,2)(1,2), B=3.
  - J: (1,0)(1,1)(1,2)(0,2), B=3.
  - S: (1,0)(2,0)(0,1)(1,1), B=3.
  - Z: (0,0)(1,0)(1,1)(2,1), B=3.
- Rotation: each clockwise step maps (dx,dy) -> (B-1-dy, dx), applied rot times.
- Cell coordinates: col = x+dx, row = y+dy, computed at 4 bits. A cell is out of bounds if col>7 or row>7.
- blk_n is listed in rot0 offset order after rotation.
- Footprint legality: all four cells in bounds and fallen[row][col]=0 for each.
- Move selection per cycle: exactly one request is honoured, by priority rotate > left > right > down.
  - "Down" means btn_down_en OR clk_en. Both together give a single step.
- Candidates:
  - rotate: rot+1 mod 4 (3 wraps to 0); no wall kick.
  - left: x-1; illegal when cur_pos_x=0 (no wrap).
  - right: x+1.
  - down: y+1.
- Update: on posedge clk, if the selected candidate footprint is legal, new_* <= candidate; otherwise new_* <= cur_*. With no request, new_* <= cur_*.
- A lower-priority request is never substituted when the higher-priority one is illegal.
- A blocked down leaves the position unchanged. Landing detection is downstream's job.
- Latency: new_* valid one clock after the request.
- blk_* and is_possible are combinational from new_*, piece and fallen. Out-of-bounds cells are truncated to 3-bit coordinates; in that case is_possible=0.
- Randomizer:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifted every clock.
  - random_num = lfsr mod 7, registered.
  - Period 255.
- Reset:
  - new_pos_x=3, new_pos_y=0, new_rot=0.
  - lfsr=LFSR_SEED, random_num=LFSR_SEED mod 7 (=4).
- A reset asserted during a request wins over the request.

Decomposition:
- Package tetris_pkg holds:
  - piece code enum.
  - offset/box-size tables.
  - BOARD_W/H.
  - spawn constants (x=3, y=0, rot=0).
  - LFSR seed and taps.
- One natural sub-module: piece_footprint. It is combinational: piece, x, y, rot, fallen -> four cells plus legal.
  - Instantiated once for the move candidate and once for the new_* outputs.

Test Plan:
- Reset, piece=2 (T), empty board -> new=(3,0,0); blk = 3,4,5,12; is_possible=1. Random_num=4 after reset; over 255 clocks all values are in 0..6 and the sequence repeats at 255.
- Same as above, then set fallen[1][4]=1 -> is_possible=0 with no clock edge needed.
- cur=(0,2,0), piece O, left -> new_x stays 0. cur=(6,2,0), piece O, right -> new_x stays 6 (col 8 out). cur=(5,2,0), right -> new_x=6.
- piece I, cur_rot=3, rotate -> new_rot=0. At (2,0) rot1 -> blk = 4,12,20,28.
- piece O at (3,5), empty board, clk_en -> new_y=6. At (3,6), clk_en -> new_y stays 6 (row 8). At (3,2) with fallen[4][3]=1, btn_down_en -> new_y stays 2.
- rotate+left+clk_en together, rotation legal -> only new_rot changes. Same inputs with rotation blocked -> new_* = cur_* (no fallback to left/down).
